ex_flag_stage: RTL and testbench
================================

EX_FLAG_STAGE -- requirements
Module: ex_flag_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 in_valid / in_ready  in / out  1 / 1  upstream handshake from the ALU stage.
REQ-005 alu_out  in  16  saturated ALU result; alu_zr, alu_neg, alu_ov  in  1 each  ALU flags.
REQ-006 set_zno  in  1  instruction updates Z, N, V (ADD/SUB class); set_z  in  1  updates Z only (logical class).
REQ-007 is_br  in  1  conditional branch; br_cond  in  3  condition code; br_target  in  16  target PC.
REQ-008 dst_in  in  4  destination register; we_in  in  1  register write enable.
REQ-009 flush  in  1  kill the held entry and the incoming instruction.
REQ-010 out_valid / out_ready  out / in  1 / 1  downstream handshake to writeback.
REQ-011 out_result  out  16; out_dst  out  4; out_we  out  1; held entry payload.
REQ-012 br_taken  out  1; br_pc  out  16; branch resolution, qualified by out_valid.
REQ-013 flag_z, flag_n, flag_v  out  1 each  architectural flag register.
REQ-014 ov_count  out  8  saturating count of committed overflows.

Function
REQ-015 Occupancy SHALL be a two-state FSM, EMPTY and FULL; out_valid=1 exactly in FULL.
REQ-016 in_ready SHALL equal (state==EMPTY) or out_ready; in_ready SHALL NOT depend on in_valid.
REQ-017 Accept = in_valid & in_ready & ~flush; on accept the entry SHALL be captured and the state SHALL be FULL next cycle.
REQ-018 Transfer = out_valid & out_ready; transfer without accept SHALL go to EMPTY; simultaneous transfer and accept SHALL stay FULL with the new entry.
REQ-019 Latency SHALL be one cycle from accept to out_valid; full throughput when out_ready stays high.
REQ-020 Flags SHALL commit on transfer only: set_zno writes Z,N,V from the held entry; set_z writes Z only; neither leaves flags unchanged; set_zno SHALL take priority if both are set.
REQ-021 Branch evaluation SHALL occur at accept using effective flags: the held entry's pending flags (per REQ-020 masking) when FULL and that entry sets flags, otherwise the architectural flags.
REQ-022 Condition codes: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-023 br_taken SHALL be registered with the entry; br_taken=0 whenever is_br=0; br_pc SHALL equal br_target of the held entry.
REQ-024 flush SHALL force EMPTY next cycle, discard the held entry's pending flag update and ov_count increment, and block accept that cycle; flush has priority over transfer.
REQ-025 ov_count SHALL increment by 1 on transfer of a set_zno entry with alu_ov=1, and SHALL saturate at 255 (no wrap).
REQ-026 Payload registers SHALL hold their value while FULL and out_ready=0.

Reset
REQ-027 On rst_n=0: state EMPTY, out_valid=0, out_result=0, out_dst=0, out_we=0, br_taken=0, br_pc=0, flag_z=flag_n=flag_v=0, ov_count=0.
REQ-028 Reset asserted mid-transfer SHALL drop the held entry with no flag or counter update.
REQ-029 in_ready SHALL be 1 during and immediately after reset.

Structure
REQ-030 Condition-code constants and the flag-set bundle (z, n, v) SHALL live in shared package wisc_pkg.
REQ-031 Condition evaluation SHALL be a combinational sub-module br_cond_eval (inputs cond, z, n, v; output taken).

Verification
REQ-032 SUB result 0x0000, zr=1, set_zno, out_ready=1 -> out_result=0x0000 one cycle later; flag_z=1, flag_n=0, flag_v=0 after transfer.
REQ-033 set_zno op with alu_ov=1, alu_neg=1, result 0x8000, followed back-to-back by branch cond 110 -> br_taken=1 via forwarding, br_pc=br_target.
REQ-034 out_ready=0 for 3 cycles with FULL -> in_ready=0, payload stable, flags unchanged; release -> single transfer, flags update once.
REQ-035 Flush while FULL holding a set_zno ov=1 entry -> out_valid=0 next cycle, flags and ov_count unchanged.
REQ-036 260 committed ov=1 set_zno entries -> ov_count=255, no wrap to 4.
REQ-037 Logical op with set_z, zr=0, after flags Z=1,N=1 -> flag_z=0, flag_n=1 retained; branch cond 011 then -> br_taken=1.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared definitions for the execute/flag stage: condition codes, the flag bundle,
// the occupancy states and the held-entry layout.
package wisc_pkg;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;
  localparam logic [2:0] CC_UN = 3'b111;

  localparam logic [7:0] OV_CNT_MAX = 8'hFF;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } flags_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } occ_state_e;

  typedef struct packed {
    logic [15:0] result;
    logic [3:0]  dst;
    logic        we;
    logic        set_zno;
    logic        set_z;
    flags_t      alu_fl;
    logic        br_taken;
    logic [15:0] br_pc;
  } entry_t;

  // Flags that result from committing an entry on top of the architectural set.
  // set_zno wins over set_z; with neither, the architectural flags pass through.
  function automatic flags_t apply_flags(input flags_t arch, input logic set_zno,
                                         input logic set_z, input flags_t alu);
    flags_t f;
    f = arch;
    if (set_zno) begin
      f = alu;
    end else if (set_z) begin
      f.z = alu.z;
    end
    return f;
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluation against a Z/N/V flag set.
module br_cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       n,
  input  logic       v,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_NE:   taken = ~z;
      CC_EQ:   taken = z;
      CC_GT:   taken = ~z & ~n;
      CC_LT:   taken = n;
      CC_GE:   taken = z | (~z & ~n);
      CC_LE:   taken = n | z;
      CC_OV:   taken = v;
      CC_UN:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flag_stage.sv
// One-entry valid/ready stage that commits ALU flags on transfer and resolves branches on accept.
// Latency 1 cycle, full throughput; in_ready = empty | out_ready; flush beats transfer.
module ex_flag_stage
  import wisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_neg,
  input  logic        alu_ov,
  input  logic        set_zno,
  input  logic        set_z,
  input  logic        is_br,
  input  logic [2:0]  br_cond,
  input  logic [15:0] br_target,
  input  logic [3:0]  dst_in,
  input  logic        we_in,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_dst,
  output logic        out_we,
  output logic        br_taken,
  output logic [15:0] br_pc,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v,
  output logic [7:0]  ov_count
);

  occ_state_e state_q, state_d;
  entry_t     entry_q, entry_d;
  flags_t     arch_q, arch_d;
  logic [7:0] ov_q, ov_d;

  logic   accept;
  logic   xfer;
  logic   commit;
  logic   cond_taken;
  flags_t eff_fl;
  flags_t in_fl;

  assign in_ready = (state_q == ST_EMPTY) | out_ready;
  assign accept   = in_valid & in_ready & ~flush;
  assign xfer     = out_valid & out_ready;
  assign commit   = xfer & ~flush;
  assign in_fl    = '{z: alu_zr, n: alu_neg, v: alu_ov};

  // An accept while FULL always coincides with the held entry's transfer, so a
  // branch must see the flags that entry is about to commit.
  assign eff_fl = (state_q == ST_FULL)
                ? apply_flags(arch_q, entry_q.set_zno, entry_q.set_z, entry_q.alu_fl)
                : arch_q;

  br_cond_eval u_br_cond_eval (
    .cond  (br_cond),
    .z     (eff_fl.z),
    .n     (eff_fl.n),
    .v     (eff_fl.v),
    .taken (cond_taken)
  );

  always_comb begin
    state_d   = state_q;
    out_valid = (state_q == ST_FULL);
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_FULL;
    end else if (xfer) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    entry_d = entry_q;
    if (accept) begin
      entry_d.result   = alu_out;
      entry_d.dst      = dst_in;
      entry_d.we       = we_in;
      entry_d.set_zno  = set_zno;
      entry_d.set_z    = set_z;
      entry_d.alu_fl   = in_fl;
      entry_d.br_taken = is_br & cond_taken;
      entry_d.br_pc    = br_target;
    end
  end

  always_comb begin
    arch_d = arch_q;
    ov_d   = ov_q;
    if (commit) begin
      arch_d = apply_flags(arch_q, entry_q.set_zno, entry_q.set_z, entry_q.alu_fl);
      if (entry_q.set_zno && entry_q.alu_fl.v && (ov_q != OV_CNT_MAX)) begin
        ov_d = ov_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      entry_q <= '0;
      arch_q  <= '0;
      ov_q    <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      arch_q  <= arch_d;
      ov_q    <= ov_d;
    end
  end

  assign out_result = entry_q.result;
  assign out_dst    = entry_q.dst;
  assign out_we     = entry_q.we;
  assign br_taken   = entry_q.br_taken;
  assign br_pc      = entry_q.br_pc;
  assign flag_z     = arch_q.z;
  assign flag_n     = arch_q.n;
  assign flag_v     = arch_q.v;
  assign ov_count   = ov_q;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed bench for ex_flag_stage: a per-cycle vector table plus hand sequences
// for stall, flush, mid-transfer reset and overflow-counter saturation.
module tb_ex_flag_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] alu_out = '0;
  logic        alu_zr = 1'b0;
  logic        alu_neg = 1'b0;
  logic        alu_ov = 1'b0;
  logic        set_zno = 1'b0;
  logic        set_z = 1'b0;
  logic        is_br = 1'b0;
  logic [2:0]  br_cond = '0;
  logic [15:0] br_target = '0;
  logic [3:0]  dst_in = 4'h3;
  logic        we_in = 1'b1;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic [3:0]  out_dst;
  logic        out_we;
  logic        br_taken;
  logic [15:0] br_pc;
  logic        flag_z, flag_n, flag_v;
  logic [7:0]  ov_count;

  int total = 0;
  int bad   = 0;

  ex_flag_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_neg(alu_neg), .alu_ov(alu_ov),
    .set_zno(set_zno), .set_z(set_z), .is_br(is_br), .br_cond(br_cond),
    .br_target(br_target), .dst_in(dst_in), .we_in(we_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dst(out_dst), .out_we(out_we), .br_taken(br_taken), .br_pc(br_pc),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .ov_count(ov_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] res;
    logic        zr, neg, ov, szno, sz, isbr;
    logic [2:0]  cond;
    logic [15:0] tgt;
    logic        ordy;
    logic        e_ovld;
    logic [15:0] e_res;
    logic        e_brt;
    logic [15:0] e_pc;
    logic [2:0]  e_flg;
    logic [7:0]  e_ov;
    logic        e_irdy;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] res, input logic zr, input logic neg,
                       input logic ov, input logic szno, input logic sz, input logic isbr,
                       input logic [2:0] cond, input logic [15:0] tgt, input logic ordy);
    in_valid  = iv;   alu_out = res;  alu_zr = zr;   alu_neg = neg; alu_ov = ov;
    set_zno   = szno; set_z   = sz;   is_br  = isbr; br_cond = cond;
    br_target = tgt;  out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input logic ovld, input logic [2:0] flg,
                           input logic [7:0] ovc);
    chk({nm, ".out_valid"}, {31'd0, out_valid}, {31'd0, ovld});
    chk({nm, ".flags"}, {29'd0, flag_z, flag_n, flag_v}, {29'd0, flg});
    chk({nm, ".ov_count"}, {24'd0, ov_count}, {24'd0, ovc});
  endtask

  initial begin
    //          iv res      zr neg ov zno z  br cond tgt      ordy | ovld res     brt pc       flg     ov  irdy
    tbl[0]  = '{1, 16'h0000, 1, 0, 0, 1, 0, 0, 3'd0, 16'h0000, 1,   1, 16'h0000, 0, 16'h0000, 3'b000, 0, 1};
    tbl[1]  = '{0, 16'h0000, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 1,   0, 16'h0000, 0, 16'h0000, 3'b100, 0, 1};
    tbl[2]  = '{1, 16'h8000, 0, 1, 1, 1, 0, 0, 3'd0, 16'h0000, 1,   1, 16'h8000, 0, 16'h0000, 3'b100, 0, 1};
    tbl[3]  = '{1, 16'h0055, 0, 0, 0, 0, 0, 1, 3'd6, 16'h1234, 1,   1, 16'h0055, 1, 16'h1234, 3'b011, 1, 1};
    tbl[4]  = '{1, 16'h0004, 0, 0, 0, 0, 0, 1, 3'd0, 16'h2000, 1,   1, 16'h0004, 1, 16'h2000, 3'b011, 1, 1};
    tbl[5]  = '{1, 16'h0005, 0, 0, 0, 0, 0, 1, 3'd1, 16'h2001, 1,   1, 16'h0005, 0, 16'h2001, 3'b011, 1, 1};
    tbl[6]  = '{1, 16'h0006, 0, 0, 0, 0, 0, 1, 3'd2, 16'h2002, 1,   1, 16'h0006, 0, 16'h2002, 3'b011, 1, 1};
    tbl[7]  = '{1, 16'h0007, 0, 0, 0, 0, 0, 1, 3'd3, 16'h2003, 1,   1, 16'h0007, 1, 16'h2003, 3'b011, 1, 1};
    tbl[8]  = '{1, 16'h0008, 0, 0, 0, 0, 0, 1, 3'd4, 16'h2004, 1,   1, 16'h0008, 0, 16'h2004, 3'b011, 1, 1};
    tbl[9]  = '{1, 16'h0009, 0, 0, 0, 0, 0, 1, 3'd5, 16'h2005, 1,   1, 16'h0009, 1, 16'h2005, 3'b011, 1, 1};
    tbl[10] = '{1, 16'h000A, 0, 0, 0, 0, 0, 1, 3'd7, 16'h2006, 1,   1, 16'h000A, 1, 16'h2006, 3'b011, 1, 1};
    tbl[11] = '{1, 16'h000B, 0, 0, 0, 0, 0, 0, 3'd7, 16'h2007, 1,   1, 16'h000B, 0, 16'h2007, 3'b011, 1, 1};
    tbl[12] = '{1, 16'h8000, 1, 1, 0, 1, 0, 0, 3'd0, 16'h0000, 1,   1, 16'h8000, 0, 16'h0000, 3'b011, 1, 1};
    tbl[13] = '{1, 16'h00FF, 0, 0, 0, 0, 1, 0, 3'd0, 16'h0000, 1,   1, 16'h00FF, 0, 16'h0000, 3'b110, 1, 1};
    tbl[14] = '{1, 16'h0014, 0, 0, 0, 0, 0, 1, 3'd0, 16'h3000, 1,   1, 16'h0014, 1, 16'h3000, 3'b010, 1, 1};
    tbl[15] = '{1, 16'h0015, 0, 0, 0, 0, 0, 1, 3'd3, 16'h3001, 1,   1, 16'h0015, 1, 16'h3001, 3'b010, 1, 1};
    tbl[16] = '{0, 16'h0000, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 1,   0, 16'h0000, 0, 16'h0000, 3'b010, 1, 1};
    tbl[17] = '{1, 16'h1111, 0, 0, 0, 1, 1, 0, 3'd0, 16'h0000, 1,   1, 16'h1111, 0, 16'h0000, 3'b010, 1, 1};
    tbl[18] = '{0, 16'h0000, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 1,   0, 16'h0000, 0, 16'h0000, 3'b000, 1, 1};

    // Reset state
    #2;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk_state("rst", 1'b0, 3'b000, 8'd0);
    chk("rst.out_result", {16'd0, out_result}, 32'd0);
    chk("rst.out_dst", {28'd0, out_dst}, 32'd0);
    chk("rst.out_we", {31'd0, out_we}, 32'd0);
    chk("rst.br_taken", {31'd0, br_taken}, 32'd0);
    chk("rst.br_pc", {16'd0, br_pc}, 32'd0);
    chk("rst.in_ready2", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    #1;
    chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

    // Per-cycle vector table
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].iv, tbl[i].res, tbl[i].zr, tbl[i].neg, tbl[i].ov, tbl[i].szno,
            tbl[i].sz, tbl[i].isbr, tbl[i].cond, tbl[i].tgt, tbl[i].ordy);
      step();
      chk_state($sformatf("vec%0d", i), tbl[i].e_ovld, tbl[i].e_flg, tbl[i].e_ov);
      chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_irdy});
      if (tbl[i].e_ovld) begin
        chk($sformatf("vec%0d.out_result", i), {16'd0, out_result}, {16'd0, tbl[i].e_res});
        chk($sformatf("vec%0d.br_taken", i), {31'd0, br_taken}, {31'd0, tbl[i].e_brt});
        chk($sformatf("vec%0d.br_pc", i), {16'd0, br_pc}, {16'd0, tbl[i].e_pc});
      end
    end

    // Stall for 3 cycles while FULL: payload and flags frozen, then one transfer
    drive(1, 16'hABCD, 0, 1, 1, 1, 0, 0, 3'd0, 16'h0000, 1);
    step();
    chk_state("stall.load", 1'b1, 3'b000, 8'd1);
    drive(1, 16'h1111, 1, 0, 0, 1, 0, 0, 3'd0, 16'h0000, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_state($sformatf("stall%0d", k), 1'b1, 3'b000, 8'd1);
      chk($sformatf("stall%0d.in_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("stall%0d.out_result", k), {16'd0, out_result}, 32'h0000ABCD);
      chk($sformatf("stall%0d.out_dst", k), {28'd0, out_dst}, 32'd3);
    end
    drive(0, 16'h0000, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 1);
    step();
    chk_state("stall.release", 1'b0, 3'b011, 8'd2);
    step();
    chk_state("stall.once", 1'b0, 3'b011, 8'd2);

    // Flush a held overflow entry while an input is offered and downstream is ready
    drive(1, 16'h7777, 1, 0, 1, 1, 0, 0, 3'd0, 16'h0000, 1);
    step();
    chk_state("flush.load", 1'b1, 3'b011, 8'd2);
    flush = 1'b1;
    step();
    chk_state("flush", 1'b0, 3'b011, 8'd2);
    flush = 1'b0;
    drive(0, 16'h0000, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 1);
    step();
    chk_state("flush.after", 1'b0, 3'b011, 8'd2);

    // Asynchronous reset while a transfer is pending
    drive(1, 16'h4242, 0, 1, 1, 1, 0, 0, 3'd0, 16'h0000, 1);
    step();
    drive(0, 16'h0000, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("midrst.async", 1'b0, 3'b000, 8'd0);
    chk("midrst.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk_state("midrst.edge", 1'b0, 3'b000, 8'd0);
    rst_n = 1'b1;
    step();
    chk_state("midrst.after", 1'b0, 3'b000, 8'd0);

    // 260 committed overflows saturate the counter
    begin
      int stalls;
      stalls = 0;
      drive(1, 16'h8001, 0, 1, 1, 1, 0, 0, 3'd0, 16'h0000, 1);
      for (int k = 0; k < 260; k++) begin
        step();
        if (!in_ready || !out_valid) stalls++;
      end
      chk("sat.stream_stalls", stalls, 0);
      drive(0, 16'h0000, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 1);
      step();
      chk_state("sat", 1'b0, 3'b011, 8'd255);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
